// File: rtl/alu_md_ctrl.sv
// ALU control decode for the EX stage plus an iterative radix-2 multiply/divide
// engine for RV32M/RV64M with a start/busy/done handshake.
module alu_md_ctrl #(
   parameter int XLEN  = 32,
   parameter bit M_EXT = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      alu_op,
   input  logic [6:0]      funct7,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   input  logic            start,
   input  logic            flush,
   output logic [3:0]      alu_ctrl,
   output logic            is_md,
   output logic            illegal,
   output logic            md_busy,
   output logic            md_done,
   output logic [XLEN-1:0] md_result
);
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   function automatic logic [3:0] base_code(input logic [2:0] f3);
      case (f3)
         3'b000:  base_code = ALU_ADD;
         3'b001:  base_code = ALU_SLL;
         3'b010:  base_code = ALU_SLT;
         3'b011:  base_code = ALU_SLTU;
         3'b100:  base_code = ALU_XOR;
         3'b101:  base_code = ALU_SRL;
         3'b110:  base_code = ALU_OR;
         default: base_code = ALU_AND;
      endcase
   endfunction

   always_comb begin
      alu_ctrl = ALU_ADD;
      is_md    = 1'b0;
      illegal  = 1'b0;
      case (alu_op)
         2'b00: alu_ctrl = ALU_ADD;
         2'b01: alu_ctrl = ALU_SUB;
         2'b10: begin
            if (funct7 == 7'b0000000)
               alu_ctrl = base_code(funct3);
            else if (funct7 == 7'b0100000 && funct3 == 3'b000)
               alu_ctrl = ALU_SUB;
            else if (funct7 == 7'b0100000 && funct3 == 3'b101)
               alu_ctrl = ALU_SRA;
            else if (funct7 == 7'b0000001 && M_EXT)
               is_md = 1'b1;
            else
               illegal = 1'b1;
         end
         default: begin
            // I-type: no SUBI, funct7 only distinguishes SRAI from SRLI
            if (funct3 == 3'b000)
               alu_ctrl = ALU_ADD;
            else if (funct3 == 3'b101 && funct7[5])
               alu_ctrl = ALU_SRA;
            else
               alu_ctrl = base_code(funct3);
         end
      endcase
   end

   generate
      if (M_EXT) begin : g_md
         localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;
         typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

         state_t            state_reg, state_next;
         logic [CW-1:0]     count_reg;
         logic [XLEN-1:0]   hi_reg, lo_reg, dvs_reg, res_reg;
         logic [2:0]        f3_reg;
         logic              negq_reg, negr_reg;

         logic              a_sgn, b_sgn, div_zero, div_ovf, accept, last_step;
         logic [XLEN-1:0]   a_mag, b_mag;
         logic [XLEN:0]     mul_sum, div_sh, div_diff;
         logic [XLEN-1:0]   hi_next, lo_next, q_fix, r_fix, final_res;
         logic [2*XLEN-1:0] prod, prod_fix;

         // Signedness per funct3: MUL low half needs no sign handling
         assign a_sgn    = (funct3 == 3'b001 || funct3 == 3'b010 || funct3 == 3'b100 ||
                            funct3 == 3'b110) && op_a[XLEN-1];
         assign b_sgn    = (funct3 == 3'b001 || funct3 == 3'b100 || funct3 == 3'b110) &&
                           op_b[XLEN-1];
         assign a_mag    = a_sgn ? -op_a : op_a;
         assign b_mag    = b_sgn ? -op_b : op_b;
         assign div_zero = funct3[2] && (op_b == '0);
         assign div_ovf  = funct3[2] && !funct3[0] && (op_b == '1) &&
                           (op_a == {1'b1, {(XLEN-1){1'b0}}});
         assign accept    = start && is_md && !flush;
         assign last_step = (count_reg == CW'(XLEN-1));

         always_comb begin
            state_next = state_reg;
            case (state_reg)
               IDLE:    if (accept) state_next = (div_zero || div_ovf) ? DONE : CALC;
               CALC:    if (last_step) state_next = DONE;
               default: state_next = IDLE;
            endcase
            if (flush) state_next = IDLE;
         end

         // hi/lo hold {accumulator, multiplier} or {remainder, dividend/quotient}
         always_comb begin
            mul_sum  = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, dvs_reg} : '0);
            div_sh   = {hi_reg, lo_reg[XLEN-1]};
            div_diff = div_sh - {1'b0, dvs_reg};
            if (f3_reg[2]) begin
               hi_next = div_diff[XLEN] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
               lo_next = {lo_reg[XLEN-2:0], ~div_diff[XLEN]};
            end else begin
               hi_next = mul_sum[XLEN:1];
               lo_next = {mul_sum[0], lo_reg[XLEN-1:1]};
            end
            prod     = {hi_next, lo_next};
            prod_fix = negq_reg ? -prod : prod;
            q_fix    = negq_reg ? -lo_next : lo_next;
            r_fix    = negr_reg ? -hi_next : hi_next;
            case (f3_reg)
               3'b000:         final_res = prod_fix[XLEN-1:0];
               3'b100, 3'b101: final_res = q_fix;
               3'b110, 3'b111: final_res = r_fix;
               default:        final_res = prod_fix[2*XLEN-1:XLEN];
            endcase
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) state_reg <= IDLE;
            else        state_reg <= state_next;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               count_reg <= '0;
               hi_reg    <= '0;
               lo_reg    <= '0;
               dvs_reg   <= '0;
               res_reg   <= '0;
               f3_reg    <= '0;
               negq_reg  <= 1'b0;
               negr_reg  <= 1'b0;
            end else if (state_reg == IDLE && accept) begin
               count_reg <= '0;
               hi_reg    <= '0;
               lo_reg    <= funct3[2] ? a_mag : b_mag;
               dvs_reg   <= funct3[2] ? b_mag : a_mag;
               f3_reg    <= funct3;
               negq_reg  <= a_sgn ^ b_sgn;
               negr_reg  <= a_sgn;
               if (div_zero)     res_reg <= funct3[1] ? op_a : '1;
               else if (div_ovf) res_reg <= funct3[1] ? '0 : op_a;
            end else if (state_reg == CALC && !flush) begin
               hi_reg    <= hi_next;
               lo_reg    <= lo_next;
               count_reg <= count_reg + 1'b1;
               if (last_step) res_reg <= final_res;
            end
         end

         assign md_busy   = (state_reg != IDLE);
         assign md_done   = (state_reg == DONE);
         assign md_result = res_reg;
      end else begin : g_no_md
         assign md_busy   = 1'b0;
         assign md_done   = 1'b0;
         assign md_result = '0;
      end
   endgenerate
endmodule

// File: tb/tb_alu_md_ctrl.sv
// Self-checking bench for alu_md_ctrl: decode table checks and M-op results
// against an arithmetic reference model, plus flush/reset/handshake timing.
module tb_alu_md_ctrl;
   localparam int XLEN = 32;
   localparam logic [31:0] MIN_INT = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  alu_op = 2'b00;
   logic [6:0]  funct7 = 7'd0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] op_a = '0, op_b = '0;
   logic        start = 1'b0, flush = 1'b0;
   logic [3:0]  alu_ctrl;
   logic        is_md, illegal, md_busy, md_done;
   logic [31:0] md_result;

   int checks = 0;
   int errors = 0;
   int n_ops = 0;
   int done_cnt = 0;

   alu_md_ctrl #(.XLEN(XLEN), .M_EXT(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .funct7(funct7), .funct3(funct3),
      .op_a(op_a), .op_b(op_b), .start(start), .flush(flush), .alu_ctrl(alu_ctrl),
      .is_md(is_md), .illegal(illegal), .md_busy(md_busy), .md_done(md_done),
      .md_result(md_result)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (md_done === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference M-op arithmetic on 64-bit integers
   function automatic logic [31:0] md_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      case (f3)
         3'd0: begin p = 64'(ua * ub); return p[31:0]; end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = 64'(ua * ub); return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == MIN_INT && b == 32'hFFFF_FFFF) return a;
            return 32'(sa / sb);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
         3'd6: begin
            if (b == 0) return a;
            if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
         default: return (b == 0) ? a : 32'(ua % ub);
      endcase
   endfunction

   // Reference decode: returns {alu_ctrl, is_md, illegal}
   function automatic logic [5:0] dec_ref(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
      logic [3:0] base, c;
      logic md, ill;
      case (f3)
         3'd0: base = 4'd0;  // ADD
         3'd1: base = 4'd5;  // SLL
         3'd2: base = 4'd8;  // SLT
         3'd3: base = 4'd9;  // SLTU
         3'd4: base = 4'd4;  // XOR
         3'd5: base = 4'd6;  // SRL
         3'd6: base = 4'd3;  // OR
         default: base = 4'd2; // AND
      endcase
      c = 4'd0; md = 1'b0; ill = 1'b0;
      if (op == 2'b01) c = 4'd1;
      else if (op == 2'b11) c = (f3 == 3'd0) ? 4'd0 : ((f3 == 3'd5 && f7[5]) ? 4'd7 : base);
      else if (op == 2'b10) begin
         if (f7 == 7'h00) c = base;
         else if (f7 == 7'h20 && f3 == 3'd0) c = 4'd1;
         else if (f7 == 7'h20 && f3 == 3'd5) c = 4'd7;
         else if (f7 == 7'h01) md = 1'b1;
         else ill = 1'b1;
      end
      return {c, md, ill};
   endfunction

   task automatic chk_dec(input string tag, input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3);
      logic [5:0] e;
      alu_op = op; funct7 = f7; funct3 = f3;
      #1;
      e = dec_ref(op, f7, f3);
      chk(tag, {58'd0, alu_ctrl, is_md, illegal}, {58'd0, e});
   endtask

   // Issue one M op; md_done is seen after edge XLEN (edge 0 for special
   // divides), i.e. it is high when edge XLEN+1 (resp. 1) samples it.
   task automatic run_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input bit poke);
      int done_e, exp_lat;
      bit busy_ok;
      logic [31:0] exp;
      exp = md_ref(f3, a, b);
      exp_lat = ((f3[2] && b == 0) || (f3[2] && !f3[0] && a == MIN_INT && b == 32'hFFFF_FFFF)) ? 0 : XLEN;
      @(negedge clk);
      alu_op = 2'b10; funct7 = 7'h01; funct3 = f3; op_a = a; op_b = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      done_e = -1;
      busy_ok = 1'b1;
      for (int e = 0; e <= XLEN + 4; e++) begin
         if (md_done === 1'b1) begin
            done_e = e;
            break;
         end
         if (md_busy !== 1'b1) busy_ok = 1'b0;
         if (poke && e == 3) begin
            start = 1'b1; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
         end else start = 1'b0;
         @(posedge clk); #1;
      end
      start = 1'b0;
      chk("md_latency", 64'(done_e), 64'(exp_lat));
      chk("md_busy_during", {63'd0, busy_ok & md_busy}, 64'd1);
      chk("md_result", {32'd0, md_result}, {32'd0, exp});
      @(posedge clk); #1;
      chk("md_done_pulse", {63'd0, md_done}, 64'd0);
      chk("md_idle_after", {63'd0, md_busy}, 64'd0);
      n_ops++;
      $display("txn md f3=%0d a=%h b=%h result=%h expected=%h done_edge=%0d", f3, a, b, md_result, exp, done_e);
   endtask

   logic [31:0] prev, ra, rb;
   logic [2:0]  rf;

   initial begin
      // Reset state, and decode stays live during reset
      #12;
      chk("rst_busy", {63'd0, md_busy}, 64'd0);
      chk("rst_done", {63'd0, md_done}, 64'd0);
      chk("rst_result", {32'd0, md_result}, 64'd0);
      chk_dec("dec_in_reset", 2'b01, 7'h00, 3'd0);
      @(negedge clk); rst_n = 1'b1;

      chk_dec("dec_sra", 2'b10, 7'h20, 3'd5);
      chk("dec_sra_code", {60'd0, alu_ctrl}, 64'd7);
      chk_dec("dec_i_addi", 2'b11, 7'h20, 3'd0);
      chk("dec_i_add_code", {60'd0, alu_ctrl}, 64'd0);
      chk_dec("dec_branch", 2'b01, 7'h7f, 3'd7);
      chk_dec("dec_illegal", 2'b10, 7'h20, 3'd7);
      chk("dec_illegal_flag", {62'd0, illegal, alu_ctrl == 4'd0}, 64'd3);
      chk_dec("dec_srai", 2'b11, 7'h20, 3'd5);
      chk_dec("dec_ldst", 2'b00, 7'h55, 3'd3);
      for (int i = 0; i < 60; i++) begin
         logic [6:0] f7;
         case ($urandom_range(3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'h01;
            default: f7 = 7'($urandom);
         endcase
         chk_dec("dec_rand", 2'($urandom), f7, 3'($urandom));
      end

      // Directed M ops
      run_md(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
      run_md(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
      run_md(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_md(3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1);
      run_md(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
      run_md(3'd5, 32'd5, 32'd0, 1'b0);
      run_md(3'd7, 32'd5, 32'd0, 1'b0);
      run_md(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_md(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_md(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0);

      // Randomized M ops with occasional boundary operands
      for (int i = 0; i < 14; i++) begin
         rf = 3'($urandom);
         ra = $urandom;
         rb = $urandom;
         if (i % 4 == 1) rb = 32'($urandom_range(15));
         if (i % 5 == 2) rb = 32'd0;
         if (i % 6 == 3) begin ra = MIN_INT; rb = 32'hFFFF_FFFF; end
         run_md(rf, ra, rb, i[0]);
      end

      // Flush mid-CALC, then immediate re-issue
      prev = md_result;
      @(negedge clk);
      alu_op = 2'b10; funct7 = 7'h01; funct3 = 3'd4; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy", {63'd0, md_busy}, 64'd0);
      chk("flush_done", {63'd0, md_done}, 64'd0);
      chk("flush_result_held", {32'd0, md_result}, {32'd0, prev});
      $display("txn flush at edge 10 busy=%b result=%h", md_busy, md_result);
      run_md(3'd4, 32'd100, 32'd7, 1'b0);

      // flush and start together in IDLE: flush wins
      @(negedge clk);
      funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      chk("flush_start_busy", {63'd0, md_busy}, 64'd0);
      $display("txn flush+start busy=%b", md_busy);

      // Async reset mid-CALC
      @(negedge clk);
      funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_busy", {63'd0, md_busy}, 64'd0);
      chk("async_rst_result", {32'd0, md_result}, 64'd0);
      $display("txn async reset mid-CALC busy=%b result=%h", md_busy, md_result);
      @(negedge clk); rst_n = 1'b1;
      run_md(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);

      repeat (3) @(posedge clk);
      #1;
      chk("done_count", 64'(done_cnt), 64'(n_ops));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
